// File: rtl/rect_raster_gen.sv
// Rectangle scan-coordinate generator: emits x/y/addr in raster order with back-pressure.
// Define RECT_RASTER_CLIP_EN to suppress plot for pixels outside SCREEN_W x SCREEN_H.
module rect_raster_gen #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    input  logic              stall,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

    stateT             stateQ, stateD;
    logic [X_W-1:0]    x0Q, x0D, wQ, wD, colQ, colD, xQ;
    logic [Y_W-1:0]    y0Q, y0D, hQ, hD, rowQ, rowD, yQ;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic              plotQ;
    logic              accept, lastCol, lastRow;
    logic [X_W-1:0]    xNext;
    logic [Y_W-1:0]    yNext;
    logic              inScreen;

    // Clipped pixels are never written, so they advance even under stall.
    assign accept  = (stateQ == StRun) && (!stall || !plotQ);
    assign lastCol = (colQ == wQ - X_W'(1));
    assign lastRow = (rowQ == hQ - Y_W'(1));

`ifdef RECT_RASTER_CLIP_EN
    logic [X_W:0] sumX;
    logic [Y_W:0] sumY;

    assign sumX     = {1'b0, x0D} + {1'b0, colD};
    assign sumY     = {1'b0, y0D} + {1'b0, rowD};
    assign inScreen = (sumX < (X_W+1)'(SCREEN_W)) && (sumY < (Y_W+1)'(SCREEN_H));
    assign xNext    = sumX[X_W-1:0];
    assign yNext    = sumY[Y_W-1:0];
`else
    logic unusedScreen;

    assign unusedScreen = ^{SCREEN_W, SCREEN_H};
    assign inScreen     = 1'b1;
    assign xNext        = x0D + colD;
    assign yNext        = y0D + rowD;
`endif

    always_comb begin
        stateD = stateQ;
        x0D    = x0Q;
        y0D    = y0Q;
        wD     = wQ;
        hD     = hQ;
        colD   = colQ;
        rowD   = rowQ;
        addrD  = addrQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    x0D    = x0;
                    y0D    = y0;
                    wD     = w;
                    hD     = h;
                    colD   = '0;
                    rowD   = '0;
                    addrD  = '0;
                    stateD = (w == '0 || h == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    if (!lastCol) begin
                        colD  = colQ + X_W'(1);
                        addrD = addrQ + ADDR_W'(1);
                    end else if (!lastRow) begin
                        colD  = '0;
                        rowD  = rowQ + Y_W'(1);
                        addrD = addrQ + ADDR_W'(1);
                    end else begin
                        stateD = StDone;
                    end
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            x0Q    <= '0;
            y0Q    <= '0;
            wQ     <= '0;
            hQ     <= '0;
            colQ   <= '0;
            rowQ   <= '0;
            addrQ  <= '0;
            xQ     <= '0;
            yQ     <= '0;
            plotQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            x0Q    <= x0D;
            y0Q    <= y0D;
            wQ     <= wD;
            hQ     <= hD;
            colQ   <= colD;
            rowQ   <= rowD;
            addrQ  <= addrD;
            if (stateD == StRun) begin
                xQ <= xNext;
                yQ <= yNext;
            end
            plotQ  <= (stateD == StRun) && inScreen;
        end
    end

    assign x    = xQ;
    assign y    = yQ;
    assign addr = addrQ;
    assign plot = plotQ;
    assign busy = (stateQ != StIdle);
    assign done = (stateQ == StDone);

endmodule

// File: tb/tb_rect_raster_gen.sv
// Scoreboard bench for rect_raster_gen: stimulus queues expected pixels, a monitor pops them.
module tb_rect_raster_gen;

    logic        clk = 1'b0;
    logic        reset, start, stall;
    logic [7:0]  x0, w, x;
    logic [6:0]  y0, h, y;
    logic [14:0] addr;
    logic        plot, busy, done;

    typedef struct packed {
        logic [7:0]  px;
        logic [6:0]  py;
        logic [14:0] pa;
    } pixelT;

    pixelT expQ[$];
    pixelT mExp;
    int    checks = 0;
    int    errors = 0;
    int    doneCount = 0;
    int    dc;

    always #5 clk = ~clk;

    rect_raster_gen dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x0    (x0),
        .y0    (y0),
        .w     (w),
        .h     (h),
        .stall (stall),
        .x     (x),
        .y     (y),
        .addr  (addr),
        .plot  (plot),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every accepted pixel must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (plot === 1'b1 && stall === 1'b0) begin
                check("pixel expected", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    mExp = expQ.pop_front();
                    check("pixel x", x, mExp.px);
                    check("pixel y", y, mExp.py);
                    check("pixel addr", addr, mExp.pa);
                end
            end
            if (done === 1'b1) begin
                doneCount++;
                check("queue empty at done", expQ.size(), 0);
                check("plot low at done", plot, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRect(input int ox, input int oy, input int ww, input int hh, input int lim);
        int    n = 0;
        pixelT p;
        for (int r = 0; r < hh; r++) begin
            for (int c = 0; c < ww; c++) begin
                if (n < lim) begin
                    p.px = 8'(ox + c);
                    p.py = 7'(oy + r);
                    p.pa = 15'(r * ww + c);
                    expQ.push_back(p);
                    n++;
                end
            end
        end
    endtask

    task automatic doStart(input int ox, input int oy, input int ww, input int hh);
        x0 = 8'(ox);
        y0 = 7'(oy);
        w  = 8'(ww);
        h  = 7'(hh);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // n0 is the cycle index (1 = first cycle after start) at call time.
    task automatic waitDone(input int n0, input int expN, input string name);
        int n = n0;
        while (done !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        check(name, n, expN);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        x0 = '0;
        y0 = '0;
        w  = '0;
        h  = '0;
        step();
        step();
        check("reset x", x, 0);
        check("reset y", y, 0);
        check("reset addr", addr, 0);
        check("reset plot", plot, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        reset = 1'b0;
        step();

        // Basic 3x2 scan
        pushRect(10, 30, 3, 2, 1000);
        doStart(10, 30, 3, 2);
        check("basic first plot", plot, 1);
        check("basic busy", busy, 1);
        waitDone(1, 7, "basic done cycle");
        step();
        check("basic busy after done", busy, 0);
        check("basic done one cycle", done, 0);

        // Stall for two cycles on the second pixel
        pushRect(10, 30, 3, 2, 1000);
        doStart(10, 30, 3, 2);
        step();
        stall = 1'b1;
        check("stall x", x, 11);
        step();
        check("stall hold x", x, 11);
        check("stall hold addr", addr, 1);
        step();
        check("stall hold plot", plot, 1);
        check("stall hold addr 2", addr, 1);
        stall = 1'b0;
        waitDone(4, 9, "stall done cycle");
        step();

        // Zero-size rectangle
        dc = doneCount;
        doStart(5, 5, 0, 5);
        check("zero done", done, 1);
        check("zero plot", plot, 0);
        step();
        check("zero done pulse", done, 0);
        check("zero busy", busy, 0);
        check("zero done count", doneCount - dc, 1);

        // Mid-run reset after 100 accepted pixels
        pushRect(36, 30, 40, 40, 100);
        doStart(36, 30, 40, 40);
        repeat (99) step();
        check("midrun addr", addr, 99);
        check("midrun x", x, 55);
        check("midrun y", y, 32);
        step();
        reset = 1'b1;
        dc = doneCount;
        step();
        check("midrun rst x", x, 0);
        check("midrun rst y", y, 0);
        check("midrun rst addr", addr, 0);
        check("midrun rst plot", plot, 0);
        check("midrun rst busy", busy, 0);
        check("midrun rst done", done, 0);
        reset = 1'b0;
        step();
        step();
        check("midrun no done", doneCount - dc, 0);
        pushRect(10, 30, 3, 2, 1000);
        doStart(10, 30, 3, 2);
        waitDone(1, 7, "post-reset done cycle");
        step();

        // Start while busy and in the DONE cycle is ignored
        pushRect(10, 30, 3, 2, 1000);
        dc = doneCount;
        doStart(10, 30, 3, 2);
        step();
        x0 = '0;
        y0 = '0;
        w  = 8'd1;
        h  = 7'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy start x", x, 12);
        check("busy start y", y, 30);
        waitDone(3, 7, "busy start done cycle");
        start = 1'b1;
        step();
        start = 1'b0;
        check("done-cycle start busy", busy, 0);
        check("done-cycle start plot", plot, 0);
        step();
        check("done-cycle start still idle", busy, 0);
        check("busy start single done", doneCount - dc, 1);

`ifdef RECT_RASTER_CLIP_EN
        // Right-edge clipping; clipped pixels advance despite stall
        pushRect(158, 0, 2, 1, 1000);
        doStart(158, 0, 4, 1);
        check("clip x158 plot", plot, 1);
        step();
        check("clip x159 plot", plot, 1);
        step();
        check("clip x160 plot", plot, 0);
        check("clip x160 addr", addr, 2);
        stall = 1'b1;
        step();
        check("clip x161 plot", plot, 0);
        check("clip x161 addr", addr, 3);
        waitDone(4, 5, "clip done cycle");
        stall = 1'b0;
        step();
`else
        // Modulo wrap of x and y
        pushRect(254, 127, 4, 2, 1000);
        doStart(254, 127, 4, 2);
        step();
        step();
        check("wrap x", x, 0);
        check("wrap addr", addr, 2);
        waitDone(3, 9, "wrap done cycle");
        step();
`endif

        check("queue drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
